// File: rtl/count_monitor_pkg.sv
// Shared types for the counter monitor: FSM states, lane count and lane index.
package count_monitor_pkg;

  localparam int NUM_LANES = 3;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SYNC  = 2'd2,
    CHECK = 2'd3
  } state_t;

endpackage

// File: rtl/count_monitor_lane.sv
// One observed counter: remembers last sample and flags a value that is not last+1.
module count_monitor_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= count;
  end

  // Natural modulo wrap makes max -> 0 a legal step.
  assign expected = prev + 1'b1;
  assign mismatch = (count != expected);

endmodule

// File: rtl/count_monitor.sv
// Watches three free-running counters, locks once they step cleanly, then
// records the first bad step and counts every cycle with a bad step.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = 2,
  parameter int ERRW        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] count0,
  input  logic [WIDTH-1:0] count1,
  input  logic [WIDTH-1:0] count2,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_lane,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  logic [NUM_LANES-1:0][WIDTH-1:0] cnt_in;
  logic [NUM_LANES-1:0][WIDTH-1:0] exp_v;
  logic [NUM_LANES-1:0]            mis;

  assign cnt_in = {count2, count1, count0};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    count_monitor_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .count    (cnt_in[i]),
      .expected (exp_v[i]),
      .mismatch (mis[i])
    );
  end

  state_t         state, state_nxt;
  logic [LCW-1:0] lock_cnt, lock_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_nxt;
      locked   <= (state_nxt == CHECK);
    end
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_cnt;
    case (state)
      IDLE: begin
        lock_nxt = '0;
        if (en) state_nxt = PRIME;
      end
      PRIME: begin
        state_nxt = SYNC;
        lock_nxt  = '0;
      end
      SYNC: begin
        if (|mis) begin
          lock_nxt = '0;
        end else if (lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
          state_nxt = CHECK;
          lock_nxt  = LCW'(LOCK_CYCLES);
        end else begin
          lock_nxt = lock_cnt + 1'b1;
        end
      end
      CHECK: state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
    if (!en) begin
      state_nxt = IDLE;
      lock_nxt  = '0;
    end
  end

  // Scan high to low so the lowest mismatching lane is the one left selected.
  lane_idx_t first;
  always_comb begin
    first = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (mis[i]) first = lane_idx_t'(i);
  end

  logic chk_err;
  assign chk_err = (state == CHECK) && en && (|mis);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      err_lane <= '0;
      err_exp  <= '0;
      err_got  <= '0;
      err_cnt  <= '0;
    end else if (clr) begin
      err      <= 1'b0;
      err_lane <= '0;
      err_exp  <= '0;
      err_got  <= '0;
      err_cnt  <= '0;
    end else if (chk_err) begin
      if (!err) begin
        err      <= 1'b1;
        err_lane <= first;
        err_exp  <= exp_v[first];
        err_got  <= cnt_in[first];
      end
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: lock timing, wrap, capture, clear and reset.
module tb_count_monitor;

  localparam int WIDTH = 8;
  localparam int ERRW  = 16;

  logic             clk = 1'b0;
  logic             reset, en, clr;
  logic [WIDTH-1:0] count0, count1, count2;
  logic             locked, err;
  logic [1:0]       err_lane;
  logic [WIDTH-1:0] err_exp, err_got;
  logic [ERRW-1:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  count_monitor #(.WIDTH(WIDTH), .LOCK_CYCLES(2), .ERRW(ERRW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .count0   (count0),
    .count1   (count1),
    .count2   (count2),
    .locked   (locked),
    .err      (err),
    .err_lane (err_lane),
    .err_exp  (err_exp),
    .err_got  (err_got),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Present counts, take one edge, then settle before sampling.
  task automatic tick(input int c0, input int c1, input int c2);
    count0 = WIDTH'(c0);
    count1 = WIDTH'(c1);
    count2 = WIDTH'(c2);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input int e, input int ln,
                            input int ex, input int gt, input int n);
    chk({tag, ".err"},  int'(err),      e);
    chk({tag, ".lane"}, int'(err_lane), ln);
    chk({tag, ".exp"},  int'(err_exp),  ex);
    chk({tag, ".got"},  int'(err_got),  gt);
    chk({tag, ".cnt"},  int'(err_cnt),  n);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0;
    count0 = '0; count1 = '0; count2 = '0;
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("rst.locked", int'(locked), 0);
    chk_status("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Lock from 0,1,2,...: locked appears after the 4th edge with en high.
    en = 1'b1;
    tick(0, 0, 0); chk("lock.e1", int'(locked), 0);
    tick(1, 1, 1); chk("lock.e2", int'(locked), 0);
    tick(2, 2, 2); chk("lock.e3", int'(locked), 0);
    tick(3, 3, 3); chk("lock.e4", int'(locked), 1);
    for (int v = 4; v <= 10; v++) tick(v, v, v);
    chk_status("clean", 0, 0, 0, 0, 0);
    chk("clean.locked", int'(locked), 1);

    // Lane 1 skips 11.
    tick(11, 12, 11);
    chk_status("skip", 1, 1, 11, 12, 1);
    chk("skip.locked", int'(locked), 1);
    tick(12, 13, 12);
    chk_status("skip.next", 1, 1, 11, 12, 1);

    // Clear, then lanes 0 and 2 glitch together: lane 0 wins, count +1.
    clr = 1'b1;
    tick(13, 14, 13);
    clr = 1'b0;
    chk_status("clr", 0, 0, 0, 0, 0);
    tick(20, 15, 20);
    chk_status("dual", 1, 0, 14, 20, 1);
    tick(21, 16, 21);
    chk("dual.hold", int'(err_cnt), 1);

    // Clear coinciding with a jump to 254: the jump is dropped.
    clr = 1'b1;
    tick(254, 254, 254);
    clr = 1'b0;
    chk_status("clrmis", 0, 0, 0, 0, 0);
    chk("clrmis.locked", int'(locked), 1);
    tick(255, 255, 255);
    tick(0, 0, 0);
    tick(1, 1, 1);
    chk_status("wrap", 0, 0, 0, 0, 0);
    chk("wrap.locked", int'(locked), 1);
    tick(2, 2, 5);
    chk_status("late", 1, 2, 2, 5, 1);

    // Dropping en leaves lock but keeps error status.
    en = 1'b0;
    tick(6, 6, 6);
    chk("en0.locked", int'(locked), 0);
    chk_status("en0", 1, 2, 2, 5, 1);
    en = 1'b1;
    tick(7, 7, 7);
    tick(8, 8, 8);
    tick(9, 9, 9);
    tick(10, 10, 10);
    chk("relock.locked", int'(locked), 1);

    // Asynchronous reset mid-cycle clears everything immediately.
    #2 reset = 1'b1;
    #1;
    chk("arst.locked", int'(locked), 0);
    chk_status("arst", 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    tick(11, 11, 11); chk("rel.e1", int'(locked), 0);
    tick(12, 12, 12); chk("rel.e2", int'(locked), 0);
    tick(13, 13, 13); chk("rel.e3", int'(locked), 0);
    tick(14, 14, 14); chk("rel.e4", int'(locked), 1);
    chk_status("rel", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the bit width of each observed count.
REQ-002 The block SHALL have parameter LOCK_CYCLES, default 2, meaning the number of consecutive all-lane-correct cycles needed to enter checking.
REQ-003 The block SHALL have parameter ERRW, default 16, meaning the error-counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: checking enable.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of error status and counter.
REQ-008 The block SHALL have ports count0, count1 and count2, each input, WIDTH bits: the observed counter outputs of the device under test.
REQ-009 The block SHALL have port locked, output, 1 bit: high while the block is in CHECK.
REQ-010 The block SHALL have port err, output, 1 bit: sticky first-error flag.
REQ-011 The block SHALL have port err_lane, output, 2 bits: index of the lane that caused the first error.
REQ-012 The block SHALL have ports err_exp and err_got, each output, WIDTH bits: the expected and received values at the first error.
REQ-013 The block SHALL have port err_cnt, output, ERRW bits: count of error cycles, saturating.

Function
REQ-014 Each lane SHALL register its count every cycle and define expected = (previous + 1) mod 2^WIDTH; a transition from 255 to 0 with WIDTH=8 is correct.
REQ-015 A lane mismatch SHALL be asserted when the current count differs from expected; it is evaluated only after one sample has been taken since leaving IDLE.
REQ-016 The state machine SHALL have the states IDLE, PRIME, SYNC and CHECK.
REQ-017 In IDLE, when en=1, the block SHALL take samples and go to PRIME.
REQ-018 In PRIME, after one cycle, the block SHALL go to SYNC with the lock counter at 0.
REQ-019 In SYNC, the lock counter SHALL increment when all lanes match and reset to 0 on any mismatch; when the counter reaches LOCK_CYCLES, the block SHALL go to CHECK.
REQ-020 In SYNC, mismatches SHALL NOT be counted as errors.
REQ-021 In CHECK, any cycle with at least one lane mismatch SHALL increment err_cnt by 1, holding at 2^ERRW-1.
REQ-022 In CHECK, the block SHALL capture err_lane, err_exp and err_got only when err=0, then set err=1; if several lanes mismatch simultaneously, the lowest lane index SHALL win.
REQ-023 In CHECK, a mismatch SHALL NOT drop lock; the block SHALL remain in CHECK.
REQ-024 en=0 in any state SHALL force IDLE on the next edge and deassert locked; err, capture fields and err_cnt SHALL be retained.
REQ-025 clr=1 SHALL zero err, err_lane, err_exp, err_got and err_cnt on the next edge.
REQ-026 If clr=1 coincides with a CHECK mismatch, clr SHALL take priority and that cycle's mismatch SHALL be dropped; clr SHALL NOT change state.
REQ-027 locked SHALL be a registered output, high in the first cycle after the transition into CHECK.
REQ-028 Error status SHALL reflect a mismatch one cycle after the offending sample, giving a latency of 1.

Reset
REQ-029 On asserted reset, the block SHALL immediately set state to IDLE and locked, err, err_lane, err_exp, err_got, err_cnt, the lock counter and the lane registers to 0.
REQ-030 Reset asserted mid-CHECK SHALL discard the lock; after release, the block SHALL repeat PRIME and SYNC before checking.

Structure
REQ-031 Package count_monitor_pkg SHALL hold the state enum (IDLE, PRIME, SYNC, CHECK), the lane-count constant NUM_LANES=3 and the lane-index typedef.
REQ-032 Sub-module count_monitor_lane SHALL contain the previous-value register, the expected-value computation and the mismatch output, and SHALL be instantiated 3 times.
REQ-033 The top level SHALL hold the FSM, the priority capture logic and the error counter.

Verification
REQ-034 Scenario: en=1, all lanes counting 0,1,2,... -> locked rises 4 cycles after en, err=0, err_cnt=0.
REQ-035 Scenario: lanes wrap 254,255,0,1 while locked -> no error.
REQ-036 Scenario: when locked, count1 jumps from 10 to 12 -> err=1, err_lane=1, err_exp=11, err_got=12, err_cnt=1; next cycle expected=13.
REQ-037 Scenario: count0 and count2 glitch in the same cycle -> err_lane=0, err_cnt increments by exactly 1.
REQ-038 Scenario: clr together with a mismatch -> err=0, err_cnt=0; a later mismatch captures normally.
REQ-039 Scenario: reset pulse mid-CHECK -> all outputs 0 immediately; after release, locked returns only after PRIME and SYNC.
